// File: rtl/val2_shift_sequencer_pkg.sv
// Shared types and shifter-operand field positions for the Val2 shift sequencer.
package val2_seq_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  localparam int SH_AMT_HI = 11;
  localparam int SH_AMT_LO = 7;
  localparam int SH_OP_HI  = 6;
  localparam int SH_OP_LO  = 5;
  localparam int ROT_HI    = 11;
  localparam int ROT_LO    = 8;
  localparam int IMM8_HI   = 7;
  localparam int IMM8_LO   = 0;

  // Positions to shift this cycle: the remaining count, capped at the per-cycle width.
  function automatic logic [3:0] step_amt(input logic [4:0] cnt, input logic [4:0] spc);
    if (cnt > spc) return spc[3:0];
    else           return cnt[3:0];
  endfunction

endpackage

// File: rtl/val2_shift_sequencer_if.sv
// Request/response bundle between the EXE pipeline and the Val2 sequencer.
interface val2_shift_sequencer_if;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] val_Rm_in;
  logic        imm;
  logic        mem_en;
  logic [11:0] shift_oprand;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] val2_out;
  logic        busy;

  modport master (
    output flush, req_valid, val_Rm_in, imm, mem_en, shift_oprand, resp_ready,
    input  req_ready, resp_valid, val2_out, busy
  );

  modport slave (
    input  flush, req_valid, val_Rm_in, imm, mem_en, shift_oprand, resp_ready,
    output req_ready, resp_valid, val2_out, busy
  );
endinterface

// File: rtl/val2_shift_sequencer_step_shifter.sv
// One iteration of the shifter: moves data by at most a few bit positions.
module val2_step_shifter
  import val2_seq_pkg::*;
(
  input  shift_op_e   i_op,
  input  logic [31:0] i_data,
  input  logic [3:0]  i_amount,
  output logic [31:0] o_data
);

  logic [5:0] w_rot_back;
  assign w_rot_back = 6'd32 - {2'b00, i_amount};

  always_comb begin
    o_data = i_data;
    case (i_op)
      LSL: o_data = i_data << i_amount;
      LSR: o_data = i_data >> i_amount;
      ASR: o_data = $signed(i_data) >>> i_amount;
      // amount 0 shifts the wrap term by 32, which yields zero, so ROR 0 is identity
      ROR: o_data = (i_data >> i_amount) | (i_data << w_rot_back);
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/val2_shift_sequencer.sv
// Handshaked Val2 generator: captures an operand, iterates a small step shifter, holds the result.
module val2_shift_sequencer
  import val2_seq_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst_n,
  val2_shift_sequencer_if.slave bus
);

  localparam logic [4:0] SPC = 5'(SHIFT_PER_CYCLE);

  state_e      r_state, w_state_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [4:0]  r_count, w_count_nxt;
  shift_op_e   r_op, w_op_nxt;
  logic [31:0] r_val2;
  logic [3:0]  w_step;
  logic [31:0] w_step_data;
  logic        w_accept;

  assign w_step = step_amt(r_count, SPC);

  val2_step_shifter u_step (
    .i_op     (r_op),
    .i_data   (r_data),
    .i_amount (w_step),
    .o_data   (w_step_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_count_nxt = r_count;
    w_op_nxt    = r_op;
    w_accept    = bus.req_valid && (r_state == IDLE) && !bus.flush;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.mem_en) begin
            w_data_nxt  = {20'b0, bus.shift_oprand};
            w_count_nxt = 5'd0;
            w_op_nxt    = LSL;
          end else if (bus.imm) begin
            w_data_nxt  = {24'b0, bus.shift_oprand[IMM8_HI:IMM8_LO]};
            w_count_nxt = {bus.shift_oprand[ROT_HI:ROT_LO], 1'b0};
            w_op_nxt    = ROR;
          end else begin
            w_data_nxt  = bus.val_Rm_in;
            w_count_nxt = bus.shift_oprand[SH_AMT_HI:SH_AMT_LO];
            w_op_nxt    = shift_op_e'(bus.shift_oprand[SH_OP_HI:SH_OP_LO]);
          end
          w_state_nxt = (w_count_nxt == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        w_data_nxt  = w_step_data;
        w_count_nxt = r_count - {1'b0, w_step};
        if (w_count_nxt == 5'd0) w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (bus.flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_op    <= LSL;
      r_val2  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
      r_op    <= w_op_nxt;
      // result latches only on entry to DONE, so a flush leaves the last value visible
      if (w_state_nxt == DONE && r_state != DONE) r_val2 <= w_data_nxt;
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == DONE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.val2_out   = r_val2;

endmodule
